// File: rtl/sram_march_tester.sv
`default_nettype none
// ============================================================================
// Module   : sram_march_tester
// Brief    : Four-phase march test engine (W0 / R0 / W1 / R1-descending)
//            driving an SRAM controller and checking its read data.
// Revision : 1.0  initial release
// ============================================================================
module sram_march_tester #(
  parameter int unsigned ADDR_WIDTH  = 18,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned START_ADDR  = 0,
  parameter int unsigned END_ADDR    = 2**18 - 1,
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [15:0] SEED        = 16'hAAAA
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  START,
  input  logic                  ABORT,
  output logic                  WE,
  output logic [ADDR_WIDTH-1:0] ADDRESS,
  output logic [DATA_WIDTH-1:0] DATA_WRITE,
  input  logic [DATA_WIDTH-1:0] DATA_READ,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic [1:0]            PHASE,
  output logic [15:0]           ERR_COUNT,
  output logic [ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [DATA_WIDTH-1:0] FAIL_DATA
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] END_A   = ADDR_WIDTH'(END_ADDR);
  localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(WAIT_CYCLES);

  logic [2:0]            state_q, state_d;
  logic [1:0]            phase_q, phase_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [15:0]           err_q, err_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic [DATA_WIDTH-1:0] fdata_q, fdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  hold_last;
  logic                  range_last;
  logic                  mismatch;
  logic [1:0]            next_phase;
  logic [ADDR_WIDTH-1:0] next_addr;

  // Pattern P(a) (inv=0) or its complement (inv=1); upper address bits fold into the top of the word.
  function automatic logic [DATA_WIDTH-1:0] exp_data(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic inv);
    logic [15:0] p;
    p = 16'(a) ^ {2'(32'(a) >> 16), 14'b0} ^ SEED;
    return inv ? DATA_WIDTH'(~p) : DATA_WIDTH'(p);
  endfunction

  // R1 runs descending, so its range ends at START_ADDR; the others end at END_ADDR.
  always_comb begin
    hold_last  = (cnt_q == HOLD_LAST);
    range_last = (phase_q == 2'd3) ? (addr_q == START_A) : (addr_q == END_A);
    mismatch   = (DATA_READ != exp_data(addr_q, phase_q[1]));
    next_phase = range_last ? phase_q + 2'd1 : phase_q;
    if (range_last)
      next_addr = (next_phase == 2'd3) ? END_A : START_A;
    else if (phase_q == 2'd3)
      next_addr = addr_q - ADDR_WIDTH'(1);
    else
      next_addr = addr_q + ADDR_WIDTH'(1);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RSTN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; ABORT only matters while a test is running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FINISH: if (START) state_d = S_SETUP;
      S_SETUP:          state_d = ABORT ? S_IDLE : S_HOLD;
      S_HOLD: begin
        if (ABORT)          state_d = S_IDLE;
        else if (hold_last) state_d = S_GAP;
      end
      S_GAP: begin
        if (ABORT)                              state_d = S_IDLE;
        else if (range_last && phase_q == 2'd3) state_d = S_FINISH;
        else                                    state_d = S_HOLD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: access sequencing, compare and error capture.
  always_comb begin
    phase_d = phase_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_FINISH: begin
        if (START) begin
          phase_d = 2'd0;
          addr_d  = START_A;
          we_d    = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          faddr_d = '0;
          fdata_d = '0;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        if (ABORT) begin
          we_d   = 1'b0;
          busy_d = 1'b0;
        end else begin
          wdata_d = exp_data(addr_q, phase_q[1]);
          we_d    = ~phase_q[0];
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        if (ABORT) begin
          we_d   = 1'b0;
          busy_d = 1'b0;
        end else if (hold_last) begin
          we_d = 1'b0;
          if (phase_q[0] && mismatch) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0) begin
              faddr_d = addr_q;
              fdata_d = DATA_READ;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (ABORT) begin
          we_d   = 1'b0;
          busy_d = 1'b0;
        end else if (range_last && phase_q == 2'd3) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_q == 16'd0);
          we_d   = 1'b0;
        end else begin
          phase_d = next_phase;
          addr_d  = next_addr;
          wdata_d = exp_data(next_addr, next_phase[1]);
          we_d    = ~next_phase[0];
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      phase_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign WE         = we_q;
  assign ADDRESS    = addr_q;
  assign DATA_WRITE = wdata_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PASS       = pass_q;
  assign PHASE      = phase_q;
  assign ERR_COUNT  = err_q;
  assign FAIL_ADDR  = faddr_q;
  assign FAIL_DATA  = fdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_march_tester.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sram_march_tester
// Brief    : Bench for sram_march_tester with a faultable 8-word SRAM model
//            and a timeline-based reference of the march sequence.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_march_tester;

  localparam int AW    = 18;
  localparam int DW    = 16;
  localparam int SA    = 0;
  localparam int EA    = 7;
  localparam int W     = 3;
  localparam int N     = EA - SA + 1;
  localparam int ACC   = W + 2;
  localparam int TOTAL = 1 + 4 * N * ACC;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          START = 1'b0;
  logic          ABORT = 1'b0;
  logic          WE;
  logic [AW-1:0] ADDRESS;
  logic [DW-1:0] DATA_WRITE;
  logic [DW-1:0] DATA_READ;
  logic          BUSY, DONE, PASS;
  logic [1:0]    PHASE;
  logic [15:0]   ERR_COUNT;
  logic [AW-1:0] FAIL_ADDR;
  logic [DW-1:0] FAIL_DATA;

  always #5 CLK = ~CLK;

  sram_march_tester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(SA), .END_ADDR(EA),
    .WAIT_CYCLES(W), .SEED(16'hAAAA)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .ABORT(ABORT),
    .WE(WE), .ADDRESS(ADDRESS), .DATA_WRITE(DATA_WRITE), .DATA_READ(DATA_READ),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .PHASE(PHASE),
    .ERR_COUNT(ERR_COUNT), .FAIL_ADDR(FAIL_ADDR), .FAIL_DATA(FAIL_DATA)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- faultable SRAM model ----------------
  int          fmode = 0;   // 0 clean, 1 bit0 stuck-at-0 @5, 2 reads zero, 3 xor mask @fa
  logic [2:0]  fa = '0;
  logic [15:0] fm = 16'h0001;
  logic [15:0] mem [0:7];

  function automatic logic [15:0] fault_rd(input logic [17:0] a, input logic [15:0] v);
    case (fmode)
      1:       return (a == 18'd5) ? (v & 16'hFFFE) : v;
      2:       return 16'h0000;
      3:       return (a == {15'd0, fa}) ? (v ^ fm) : v;
      default: return v;
    endcase
  endfunction

  initial for (int i = 0; i < 8; i++) mem[i] = 16'h0;

  always @(posedge CLK) if (WE === 1'b1 && ADDRESS < 8) mem[ADDRESS[2:0]] <= DATA_WRITE;

  always_comb DATA_READ = (ADDRESS < 8) ? fault_rd(ADDRESS, mem[ADDRESS[2:0]]) : 16'h0;

  // ---------------- reference model ----------------
  function automatic logic [15:0] pat(input logic [17:0] a);
    return a[15:0] ^ {a[17:16], 14'b0} ^ 16'hAAAA;
  endfunction

  // Expected access at cycle t after the START edge (t=0 is the setup cycle).
  function automatic void expect_at(input int t, output logic [17:0] a, output logic [1:0] ph,
                                    output logic we, output logic [15:0] wd);
    int k, r, idx;
    if (t == 0) begin
      a = 18'(SA); ph = 2'd0; we = 1'b0; wd = 16'h0;
    end else begin
      k   = (t - 1) / ACC;
      r   = (t - 1) % ACC;
      ph  = 2'(k / N);
      idx = k % N;
      a   = (ph == 2'd3) ? 18'(EA - idx) : 18'(SA + idx);
      we  = (ph[0] == 1'b0) && (r <= W);
      wd  = ph[1] ? ~pat(a) : pat(a);
    end
  endfunction

  bit          m_run = 0, m_done = 0, m_pass = 0;
  int          m_t = 0, m_err = 0;
  logic [17:0] m_faddr = '0, m_hold_addr = '0;
  logic [15:0] m_fdata = '0;
  logic [1:0]  m_hold_ph = '0;

  always @(posedge CLK) begin
    logic [17:0] ea;
    logic [1:0]  eph;
    logic        ewe;
    logic [15:0] ewd, ev, rv;
    if (!RSTN) begin
      m_run = 0; m_t = 0; m_done = 0; m_pass = 0; m_err = 0;
      m_faddr = '0; m_fdata = '0; m_hold_addr = '0; m_hold_ph = '0;
    end else if (m_run) begin
      expect_at(m_t, ea, eph, ewe, ewd);
      m_hold_addr = ea;
      m_hold_ph   = eph;
      if (ABORT) begin
        m_run = 0;
      end else begin
        if (m_t >= 1 && ((m_t - 1) % ACC) == W && eph[0]) begin
          ev = eph[1] ? ~pat(ea) : pat(ea);
          rv = fault_rd(ea, ev);
          if (rv != ev) begin
            if (m_err == 0) begin m_faddr = ea; m_fdata = rv; end
            if (m_err < 65535) m_err++;
          end
        end
        m_t++;
        if (m_t == TOTAL) begin
          m_run = 0; m_done = 1; m_pass = (m_err == 0);
        end
      end
    end else if (START) begin
      m_run = 1; m_t = 0; m_done = 0; m_pass = 0;
      m_err = 0; m_faddr = '0; m_fdata = '0;
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  bit cmp_en = 0;
  always @(negedge CLK) begin
    logic [17:0] ea;
    logic [1:0]  eph;
    logic        ewe;
    logic [15:0] ewd;
    if (cmp_en) begin
      if (m_run) begin
        expect_at(m_t, ea, eph, ewe, ewd);
        chk("ADDRESS", 32'(ADDRESS), 32'(ea));
        chk("PHASE",   32'(PHASE),   32'(eph));
        chk("WE",      32'(WE),      32'(ewe));
        chk("BUSY",    32'(BUSY),    32'd1);
        chk("DONE",    32'(DONE),    32'd0);
        chk("PASS",    32'(PASS),    32'd0);
        if (ewe) chk("DATA_WRITE", 32'(DATA_WRITE), 32'(ewd));
      end else begin
        chk("ADDRESS_idle", 32'(ADDRESS), 32'(m_hold_addr));
        chk("PHASE_idle",   32'(PHASE),   32'(m_hold_ph));
        chk("WE_idle",      32'(WE),      32'd0);
        chk("BUSY_idle",    32'(BUSY),    32'd0);
        chk("DONE_idle",    32'(DONE),    32'(m_done));
        chk("PASS_idle",    32'(PASS),    32'(m_pass));
      end
      chk("ERR_COUNT", 32'(ERR_COUNT), 32'(m_err));
      chk("FAIL_ADDR", 32'(FAIL_ADDR), 32'(m_faddr));
      chk("FAIL_DATA", 32'(FAIL_DATA), 32'(m_fdata));
    end
  end

  // ---------------- waveform-shape monitor ----------------
  bit          mon_en = 0;
  int          we_hi = 0, we_lo = 0;
  logic [15:0] dw5 = '0;
  logic [17:0] r1q [$];

  always @(negedge CLK) begin
    if (mon_en && BUSY) begin
      if (PHASE == 2'd0 && ADDRESS == 18'd5) begin
        if (WE) begin we_hi++; dw5 = DATA_WRITE; end
        else we_lo++;
      end
      if (PHASE == 2'd3 && (r1q.size() == 0 || r1q[$] != ADDRESS)) r1q.push_back(ADDRESS);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (DONE !== 1'b1 && n < TOTAL + 50) begin
      @(negedge CLK);
      n++;
    end
    chk(name, 32'(n), 32'(TOTAL));
  endtask

  task automatic wait_phase(input logic [1:0] ph, input string name);
    int n;
    n = 0;
    while (PHASE !== ph && n < TOTAL + 50) begin
      @(negedge CLK);
      n++;
    end
    if (PHASE !== ph) chk(name, 32'(PHASE), 32'(ph));
  endtask

  initial begin
    int act, d;
    repeat (3) @(negedge CLK);
    cmp_en = 1;
    chk("reset_BUSY", 32'(BUSY), 32'd0);
    chk("reset_ADDRESS", 32'(ADDRESS), 32'd0);
    RSTN = 1'b1;

    // 1: clean run, timing and waveform shape
    fmode = 0; mon_en = 1;
    pulse_start();
    wait_done("t1_done_edge");
    chk("t1_PASS", 32'(PASS), 32'd1);
    chk("t1_ERR", 32'(ERR_COUNT), 32'd0);
    chk("t1_we_hi", 32'(we_hi), 32'd4);
    chk("t1_we_lo", 32'(we_lo), 32'd1);
    chk("t1_dw5", 32'(dw5), 32'hAAAF);
    chk("t1_r1_len", 32'(r1q.size()), 32'd8);
    for (int i = 0; i < 8 && i < r1q.size(); i++) chk("t1_r1_order", 32'(r1q[i]), 32'(7 - i));
    mon_en = 0;

    // 2: bit0 stuck-at-0 at address 5
    fmode = 1;
    pulse_start();
    wait_done("t2_done_edge");
    chk("t2_ERR", 32'(ERR_COUNT), 32'd1);
    chk("t2_FAIL_ADDR", 32'(FAIL_ADDR), 32'd5);
    chk("t2_FAIL_DATA", 32'(FAIL_DATA), 32'hAAAE);
    chk("t2_PASS", 32'(PASS), 32'd0);

    // 3: all reads return zero
    fmode = 2;
    pulse_start();
    wait_done("t3_done_edge");
    chk("t3_ERR", 32'(ERR_COUNT), 32'd16);
    chk("t3_FAIL_ADDR", 32'(FAIL_ADDR), 32'd0);
    chk("t3_FAIL_DATA", 32'(FAIL_DATA), 32'd0);

    // 4: ABORT mid R0 with errors already counted
    pulse_start();
    begin
      int n;
      n = 0;
      while (ERR_COUNT !== 16'd3 && n < TOTAL) begin @(negedge CLK); n++; end
    end
    ABORT = 1'b1;
    @(negedge CLK); ABORT = 1'b0;
    chk("t4_BUSY", 32'(BUSY), 32'd0);
    chk("t4_WE", 32'(WE), 32'd0);
    chk("t4_DONE", 32'(DONE), 32'd0);
    chk("t4_ERR_kept", 32'(ERR_COUNT), 32'd3);
    repeat (2) @(negedge CLK);
    fmode = 0;
    pulse_start();
    chk("t4_ERR_clr", 32'(ERR_COUNT), 32'd0);
    chk("t4_PHASE", 32'(PHASE), 32'd0);
    wait_done("t4_done_edge");

    // 5: START held high through the run, then a pulse in FINISH
    @(negedge CLK); START = 1'b1;
    @(negedge CLK);
    wait_done("t5_done_edge");
    START = 1'b0;
    repeat (3) @(negedge CLK);
    chk("t5_DONE_sticky", 32'(DONE), 32'd1);
    pulse_start();
    chk("t5_DONE_clr", 32'(DONE), 32'd0);
    chk("t5_BUSY", 32'(BUSY), 32'd1);

    // 6: reset mid W1
    wait_phase(2'd2, "t6_reach_W1");
    repeat (3) @(negedge CLK);
    RSTN = 1'b0;
    @(negedge CLK); RSTN = 1'b1;
    chk("t6_WE", 32'(WE), 32'd0);
    chk("t6_BUSY", 32'(BUSY), 32'd0);
    chk("t6_ADDRESS", 32'(ADDRESS), 32'd0);
    chk("t6_PHASE", 32'(PHASE), 32'd0);
    chk("t6_DATA_WRITE", 32'(DATA_WRITE), 32'd0);

    // Randomized runs: faults, aborts and resets at random points
    for (int it = 0; it < 10; it++) begin
      fmode = $urandom_range(0, 3);
      fa    = 3'($urandom_range(0, 7));
      fm    = 16'($urandom_range(1, 65535));
      act   = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      pulse_start();
      if (act == 0) begin
        wait_done("rnd_done_edge");
      end else begin
        d = $urandom_range(1, TOTAL - 5);
        repeat (d) @(negedge CLK);
        if (act == 1) ABORT = 1'b1; else RSTN = 1'b0;
        @(negedge CLK);
        ABORT = 1'b0; RSTN = 1'b1;
      end
      repeat ($urandom_range(1, 4)) @(negedge CLK);
    end

    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_march_tester.md
Name: sram_march_tester

Overview:
Self-checking SRAM test engine that sits directly upstream of SRAM_Controller, driving its WE/ADDRESS/DATA_WRITE inputs and consuming DATA_READ.
It runs a four-phase march over a parameterised address range: write pattern, read/verify, write complement, read/verify descending.
It reports busy/done/pass, a saturating error count, and the first failing address and data.
It replaces the hand-written two-address test FSM in board-level SRAM bring-up designs.

Parameters:
ADDR_WIDTH, 18, SRAM address width
DATA_WIDTH, 16, SRAM data width
START_ADDR, 0, first address tested
END_ADDR, 2^18-1, last address tested (END_ADDR >= START_ADDR required; equal is legal)
WAIT_CYCLES, 3, extra cycles each access is held stable, to cover SRAM_Controller latency
SEED, 16'hAAAA, pattern seed

Ports:
CLK  in  1  system clock (the slow clock fed to SRAM_Controller)
RSTN  in  1  synchronous active-low reset
START  in  1  begin test; level sampled in IDLE or DONE
ABORT  in  1  cancel test in progress
WE  out  1  write enable to SRAM_Controller
ADDRESS  out  ADDR_WIDTH  address to SRAM_Controller
DATA_WRITE  out  DATA_WIDTH  write data to SRAM_Controller
DATA_READ  in  DATA_WIDTH  read data from SRAM_Controller
BUSY  out  1  test running
DONE  out  1  test completed (sticky until next START or reset)
PASS  out  1  DONE and ERR_COUNT==0
PHASE  out  2  current phase: 0=W0, 1=R0, 2=W1, 3=R1
ERR_COUNT  out  16  mismatch count, saturates at 16'hFFFF
FAIL_ADDR  out  ADDR_WIDTH  address of first mismatch
FAIL_DATA  out  DATA_WIDTH  data read at first mismatch

Behaviour:
Clock and reset:
- Single clock CLK. Reset is synchronous and active-low (RSTN); it dominates all other inputs.
- Reset values: all outputs 0, state IDLE, internal counters 0.

Pattern:
- P(a) = a[15:0] ^ {a[17:16],14'b0} ^ SEED.
- Phase W0 writes P(a) ascending. R0 reads ascending, expects P(a).
- W1 writes ~P(a) ascending. R1 reads descending (END_ADDR down to START_ADDR), expects ~P(a).

States: IDLE, SETUP, HOLD, GAP, FINISH.
- IDLE/FINISH, START=1 -> SETUP. This clears ERR_COUNT, FAIL_ADDR, FAIL_DATA, DONE and PASS; sets BUSY=1, PHASE=0, ADDRESS=START_ADDR.
- SETUP -> HOLD after 1 cycle. Loads DATA_WRITE=P(START_ADDR); WE=1 if the phase is a write.
- HOLD lasts WAIT_CYCLES+1 cycles. ADDRESS, DATA_WRITE and WE are stable throughout.
- On the last HOLD edge of a read phase: compare DATA_READ with the expected value.
  - On mismatch, ERR_COUNT increments (saturating).
  - On the first mismatch only, FAIL_ADDR and FAIL_DATA are captured.
- HOLD -> GAP. WE=0 for exactly 1 cycle while the address stays unchanged.
- GAP action:
  - Advance the address (ascending, or descending in R1). Reload DATA_WRITE for the next address. Set WE for the next access. Go to HOLD.
  - At the end of the range, advance PHASE and load its first address.
  - After R1 ends, go to FINISH.
- FINISH: BUSY=0, DONE=1, PASS=(ERR_COUNT==0), WE=0.

Timing:
- Each access takes WAIT_CYCLES+2 cycles.
- With N = END_ADDR-START_ADDR+1, DONE rises on edge 1+4·N·(WAIT_CYCLES+2) after the edge that samples START.

Boundary conditions:
- START while BUSY is ignored.
- ABORT while BUSY: on the next edge go to IDLE with WE=0 and BUSY=0. DONE stays 0. Error registers are retained.
- ABORT has priority over START in the same cycle. ABORT in IDLE or FINISH has no effect.
- N=1: each phase is a single access.
- Address counter width must not overflow at END_ADDR = 2^ADDR_WIDTH-1. Termination uses an equality compare, not wrap.
- ERR_COUNT holds at 16'hFFFF.

Test Plan:
1. Fault-free model, START_ADDR=0, END_ADDR=7, WAIT_CYCLES=3, START pulse -> DONE rises on edge 161; PASS=1, ERR_COUNT=0; a W0 write to address 5 has DATA_WRITE=16'hAAAF with WE high for 4 cycles then 1 low.
2. Model with bit0 stuck-at-0 at address 5 -> R0 mismatch only; ERR_COUNT=1, FAIL_ADDR=5, FAIL_DATA=16'hAAAE, PASS=0.
3. Model that returns 16'h0000 for every read, N=8 -> ERR_COUNT=16; FAIL_ADDR=0, FAIL_DATA=0 (first R0 access).
4. ABORT asserted mid R0 -> next edge BUSY=0, WE=0, DONE=0; a following START restarts from W0 with ERR_COUNT cleared.
5. START held high through the run -> ignored while BUSY; a START pulse in FINISH restarts the test and clears DONE.
6. RSTN low mid W1 -> on the next edge all outputs 0 and state IDLE; R1 address order checked descending 7..0 in a clean run.
